// File: rtl/pipe_run_ctrl_pkg.sv
// Shared definitions for the pipeline run-control block: FSM state type and
// the default halt encoding.
package pipe_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam logic [8:0] HALT_OP_DEFAULT = 9'b111000000;

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Signal bundle between the ID stage / run master and the run-control block.
interface pipe_run_ctrl_if #(
  parameter int INSTR_W = 9,
  parameter int REG_AW  = 3,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rd;
  logic               id_uses_rs;
  logic               id_uses_rd;
  logic               id_mem_read;
  logic               id_branch;
  logic               id_branch_cond;
  logic               run;
  logic               pc_init;
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output start, id_valid, id_instr, id_rs, id_rd, id_uses_rs, id_uses_rd,
           id_mem_read, id_branch, id_branch_cond,
    input  run, pc_init, stall, flush, branch_taken, done, cycle_count, stall_count
  );

  modport slave (
    input  start, id_valid, id_instr, id_rs, id_rd, id_uses_rs, id_uses_rd,
           id_mem_read, id_branch, id_branch_cond,
    output run, pc_init, stall, flush, branch_taken, done, cycle_count, stall_count
  );
endinterface

// File: rtl/pipe_run_ctrl_load_scoreboard.sv
// Per-register countdown of outstanding load results; reports whether an ALU
// or a branch consumer of rs/rd must still wait.
module pipe_run_ctrl_load_scoreboard #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_issue,
  input  logic [REG_AW-1:0] i_issue_rd,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd,
  output logic              o_rs_busy_alu,
  output logic              o_rs_busy_br,
  output logic              o_rd_busy_alu,
  output logic              o_rd_busy_br
);
  localparam int              SB_W  = $clog2(LOAD_LAT + 2);
  localparam int              NREG  = 2 ** REG_AW;
  localparam logic [SB_W-1:0] SET_V = SB_W'(LOAD_LAT + 1);

  logic [SB_W-1:0] r_sb [NREG];

  // A fresh issue overrides the countdown of the same entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_sb[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_issue && (i_issue_rd == REG_AW'(i))) r_sb[i] <= SET_V;
        else if (r_sb[i] != '0)                    r_sb[i] <= r_sb[i] - SB_W'(1);
      end
    end
  end

  assign o_rs_busy_alu = r_sb[i_rs] > SB_W'(1);
  assign o_rs_busy_br  = r_sb[i_rs] != '0;
  assign o_rd_busy_alu = r_sb[i_rd] > SB_W'(1);
  assign o_rd_busy_br  = r_sb[i_rd] != '0;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run-control and hazard sequencer beside ID: start/done handshake, halt
// drain, load-use stalls, branch redirect/flush and performance counters.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int                 NUM_STAGES = 5,
  parameter int                 INSTR_W    = 9,
  parameter int                 REG_AW     = 3,
  parameter logic [INSTR_W-1:0] HALT_OP    = INSTR_W'(HALT_OP_DEFAULT),
  parameter int                 LOAD_LAT   = 1,
  parameter int                 CNT_W      = 16
) (
  input logic           clk,
  input logic           reset,
  pipe_run_ctrl_if.slave bus
);
  localparam int               DRN_W      = $clog2(NUM_STAGES);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(NUM_STAGES - 3);

  run_state_e       r_state, w_next;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_pc_init;
  logic [CNT_W-1:0] r_cycle_cnt, r_stall_cnt;
  logic             w_rs_alu, w_rs_br, w_rd_alu, w_rd_br;
  logic             w_stall, w_is_halt, w_halt, w_issue, w_bt, w_launch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pipe_run_ctrl_load_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_sb (
    .clk(clk), .reset(reset),
    .i_issue(w_issue), .i_issue_rd(bus.id_rd),
    .i_rs(bus.id_rs), .i_rd(bus.id_rd),
    .o_rs_busy_alu(w_rs_alu), .o_rs_busy_br(w_rs_br),
    .o_rd_busy_alu(w_rd_alu), .o_rd_busy_br(w_rd_br)
  );

  // Branches resolve in ID, so they wait one cycle longer than ALU consumers.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == RUN && bus.id_valid) begin
      if (bus.id_branch) w_stall = (bus.id_uses_rs && w_rs_br)  || (bus.id_uses_rd && w_rd_br);
      else               w_stall = (bus.id_uses_rs && w_rs_alu) || (bus.id_uses_rd && w_rd_alu);
    end
  end

  assign w_is_halt = bus.id_instr == HALT_OP;
  assign w_halt    = (r_state == RUN) && bus.id_valid && w_is_halt && !w_stall;
  assign w_issue   = (r_state == RUN) && bus.id_valid && bus.id_mem_read && !w_stall;
  assign w_bt      = (r_state == RUN) && bus.id_valid && bus.id_branch && bus.id_branch_cond
                     && !w_stall && !w_is_halt;

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    case (r_state)
      IDLE, DONE: if (bus.start) begin w_next = RUN; w_launch = 1'b1; end
      RUN:        if (w_halt) w_next = (NUM_STAGES == 3) ? DONE : DRAIN;
      DRAIN:      if (r_drain_cnt <= DRN_W'(1)) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Drain counter, pc_init pulse and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_cnt <= '0;
      r_pc_init   <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pc_init <= w_launch;
      if (w_halt)                                         r_drain_cnt <= DRAIN_LOAD;
      else if (r_state == DRAIN && r_drain_cnt != '0)     r_drain_cnt <= r_drain_cnt - DRN_W'(1);
      if (w_launch) begin
        r_cycle_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (r_state == RUN || r_state == DRAIN) r_cycle_cnt <= sat_inc(r_cycle_cnt);
        if (w_stall)                            r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign bus.run          = r_state == RUN;
  assign bus.pc_init      = r_pc_init;
  assign bus.stall        = w_stall;
  assign bus.flush        = w_bt;
  assign bus.branch_taken = w_bt;
  assign bus.done         = r_state == DONE;
  assign bus.cycle_count  = r_cycle_cnt;
  assign bus.stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench: stimulus pushes the expected per-cycle response into a queue,
// a negedge monitor pops and compares against the selected DUT.
module tb_pipe_run_ctrl;
  import pipe_run_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_next = 1'b1;
  int   sel = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pipe_run_ctrl_if #(.INSTR_W(9), .REG_AW(3), .CNT_W(16)) ifa ();
  pipe_run_ctrl_if #(.INSTR_W(9), .REG_AW(3), .CNT_W(4))  ifb ();

  pipe_run_ctrl #(.NUM_STAGES(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pipe_run_ctrl #(.NUM_STAGES(7), .LOAD_LAT(2), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    string      nm;
    int         dut;
    logic [5:0] o;   // {run, pc_init, stall, flush, branch_taken, done}
    int         cc;  // -1: not checked
    int         sc;
  } exp_t;

  exp_t q[$];

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] act;
    int         acc, asc;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        act = {ifa.run, ifa.pc_init, ifa.stall, ifa.flush, ifa.branch_taken, ifa.done};
        acc = int'(ifa.cycle_count);
        asc = int'(ifa.stall_count);
      end else begin
        act = {ifb.run, ifb.pc_init, ifb.stall, ifb.flush, ifb.branch_taken, ifb.done};
        acc = int'(ifb.cycle_count);
        asc = int'(ifb.stall_count);
      end
      n_chk++;
      if (act === e.o) n_pass++;
      else $display("FAIL %s dut%0d outputs(run,pci,stl,fls,bt,done) got=%b exp=%b", e.nm, e.dut, act, e.o);
      if (e.cc >= 0) begin
        n_chk++;
        if (acc == e.cc) n_pass++;
        else $display("FAIL %s dut%0d cycle_count got=%0d exp=%0d", e.nm, e.dut, acc, e.cc);
      end
      if (e.sc >= 0) begin
        n_chk++;
        if (asc == e.sc) n_pass++;
        else $display("FAIL %s dut%0d stall_count got=%0d exp=%0d", e.nm, e.dut, asc, e.sc);
      end
    end
  end

  task automatic cyc(input string nm, input logic st, input logic v, input logic [8:0] ins,
                     input logic [2:0] rs, input logic [2:0] rd, input logic urs, input logic urd,
                     input logic mr, input logic br, input logic bc,
                     input logic [5:0] o, input int cc, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_next;
    if (sel == 0) begin
      ifa.start = st; ifa.id_valid = v; ifa.id_instr = ins; ifa.id_rs = rs; ifa.id_rd = rd;
      ifa.id_uses_rs = urs; ifa.id_uses_rd = urd; ifa.id_mem_read = mr;
      ifa.id_branch = br; ifa.id_branch_cond = bc;
    end else begin
      ifb.start = st; ifb.id_valid = v; ifb.id_instr = ins; ifb.id_rs = rs; ifb.id_rd = rd;
      ifb.id_uses_rs = urs; ifb.id_uses_rd = urd; ifb.id_mem_read = mr;
      ifb.id_branch = br; ifb.id_branch_cond = bc;
    end
    e.nm = nm; e.dut = sel; e.o = o; e.cc = cc; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic st, input logic [5:0] o, input int cc, input int sc);
    cyc(nm, st, 1'b0, 9'h000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, cc, sc);
  endtask

  task automatic ld(input string nm, input logic [2:0] rd, input logic [5:0] o, input int cc, input int sc);
    cyc(nm, 1'b0, 1'b1, 9'h011, 3'd0, rd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o, cc, sc);
  endtask

  task automatic alu(input string nm, input logic v, input logic [2:0] rs, input logic urs,
                     input logic [2:0] rd, input logic urd, input logic [5:0] o, input int cc, input int sc);
    cyc(nm, 1'b0, v, 9'h022, rs, rd, urs, urd, 1'b0, 1'b0, 1'b0, o, cc, sc);
  endtask

  task automatic brn(input string nm, input logic [2:0] rs, input logic c, input logic [5:0] o,
                     input int cc, input int sc);
    cyc(nm, 1'b0, 1'b1, 9'h033, rs, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, c, o, cc, sc);
  endtask

  task automatic hlt(input string nm, input logic [5:0] o, input int cc, input int sc);
    cyc(nm, 1'b0, 1'b1, HALT_OP_DEFAULT, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, cc, sc);
  endtask

  initial begin
    ifa.start = 0; ifa.id_valid = 0; ifa.id_instr = '0; ifa.id_rs = '0; ifa.id_rd = '0;
    ifa.id_uses_rs = 0; ifa.id_uses_rd = 0; ifa.id_mem_read = 0; ifa.id_branch = 0; ifa.id_branch_cond = 0;
    ifb.start = 0; ifb.id_valid = 0; ifb.id_instr = '0; ifb.id_rs = '0; ifb.id_rd = '0;
    ifb.id_uses_rs = 0; ifb.id_uses_rd = 0; ifb.id_mem_read = 0; ifb.id_branch = 0; ifb.id_branch_cond = 0;

    // Reset state, then start/halt with a start pulse ignored mid-run.
    nop("reset_state", 1'b0, 6'b000000, 0, 0);
    rst_next = 1'b0;
    nop("idle_start",  1'b1, 6'b000000, 0, 0);
    nop("r0_pc_init",  1'b0, 6'b110000, 0, 0);
    nop("r1_run",      1'b0, 6'b100000, 1, -1);
    nop("r2_start_ign",1'b1, 6'b100000, 2, -1);
    nop("r3_no_pcinit",1'b0, 6'b100000, 3, -1);
    hlt("r4_halt_id",        6'b100000, 4, -1);
    nop("r5_drain",    1'b0, 6'b000000, 5, -1);
    nop("r6_drain",    1'b0, 6'b000000, 6, -1);
    nop("r7_done",     1'b0, 6'b000001, 7, 0);
    nop("done_restart",1'b1, 6'b000001, 7, 0);

    // Load-use, branch-after-load, independent consumer, rd-side hazard.
    ld ("a0_ld_r2", 3'd2,                         6'b110000, 0, 0);
    alu("a1_use_r2", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 6'b101000, 1, 0);
    alu("a2_use_r2", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 6'b100000, 2, 1);
    ld ("a3_ld_r3", 3'd3,                         6'b100000, 3, 1);
    brn("a4_br_r3", 3'd3, 1'b1,                   6'b101000, 4, 1);
    brn("a5_br_r3", 3'd3, 1'b1,                   6'b101000, 5, 2);
    brn("a6_br_take", 3'd3, 1'b1,                 6'b100110, 6, 3);
    ld ("a7_ld_r1", 3'd1,                         6'b100000, 7, 3);
    alu("a8_indep_r4", 1'b1, 3'd4, 1'b1, 3'd1, 1'b0, 6'b100000, 8, 3);
    ld ("a9_ld_r5", 3'd5,                         6'b100000, 9, 3);
    alu("a10_rd_r5", 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 6'b101000, 10, 3);
    alu("a11_rd_r5", 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 6'b100000, 11, 4);
    ld ("a12_ld_r6", 3'd6,                        6'b100000, 12, 4);
    alu("a13_novalid", 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 6'b100000, 13, 4);
    brn("a14_br_r6", 3'd6, 1'b0,                  6'b101000, 14, 4);
    brn("a15_br_nt", 3'd6, 1'b0,                  6'b100000, 15, 5);
    hlt("a16_halt",                               6'b100000, 16, 5);
    nop("a17_drain", 1'b0,                        6'b000000, 17, -1);
    nop("a18_drain", 1'b0,                        6'b000000, 18, -1);
    nop("a19_done",  1'b0,                        6'b000001, 19, 5);

    // Reset asserted during DRAIN, then a clean run.
    nop("d0_start",  1'b1,                        6'b000001, 19, 5);
    ld ("e0_ld_r2",  3'd2,                        6'b110000, 0, 0);
    hlt("e1_halt",                                6'b100000, 1, 0);
    rst_next = 1'b1;
    nop("e2_rst_drain", 1'b0,                     6'b000000, 0, 0);
    rst_next = 1'b0;
    nop("e3_idle_start", 1'b1,                    6'b000000, 0, 0);
    brn("f0_br_clean", 3'd2, 1'b1,                6'b110110, 0, 0);
    hlt("f1_halt",                                6'b100000, 1, 0);
    nop("f2_drain",  1'b0,                        6'b000000, 2, -1);
    nop("f3_drain",  1'b0,                        6'b000000, 3, -1);
    nop("f4_done",   1'b0,                        6'b000001, 4, 0);

    // Deeper pipe, longer load latency, narrow saturating counters.
    sel = 1;
    nop("b_start",   1'b1,                        6'b000000, 0, 0);
    ld ("b0_ld_r2",  3'd2,                        6'b110000, 0, 0);
    alu("b1_use_r2", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 6'b101000, 1, 0);
    alu("b2_use_r2", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 6'b101000, 2, 1);
    alu("b3_use_r2", 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 6'b100000, 3, 2);
    ld ("b4_ld_r3",  3'd3,                        6'b100000, 4, 2);
    brn("b5_br_r3",  3'd3, 1'b1,                  6'b101000, 5, 2);
    brn("b6_br_r3",  3'd3, 1'b1,                  6'b101000, 6, 3);
    brn("b7_br_r3",  3'd3, 1'b1,                  6'b101000, 7, 4);
    brn("b8_br_take",3'd3, 1'b1,                  6'b100110, 8, 5);
    hlt("b9_halt",                                6'b100000, 9, 5);
    for (int k = 10; k < 14; k++) nop("b_drain", 1'b0, 6'b000000, k, 5);
    nop("b14_done",  1'b0,                        6'b000001, 14, 5);
    nop("b_restart", 1'b1,                        6'b000001, 14, 5);
    nop("h0_pc_init",1'b0,                        6'b110000, 0, 0);
    for (int k = 1; k < 20; k++) nop("h_sat", 1'b0, 6'b100000, (k < 15) ? k : 15, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain pending=%0d required=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Parametrised run-control and hazard sequencer for the in-order pipelined core.
- Sits beside the ID stage and replaces the ad-hoc done latch, the load-use stall detect and the branch flush glue.
- Generalised in stage count, register-file size, instruction width, halt encoding and load latency.
- Adds what the current core lacks: a start/done handshake, a halt drain counter, branch-aware load-use stalls, and cycle/stall performance counters.

Parameters:
- NUM_STAGES, 5: pipeline depth. Must be >= 3.
- INSTR_W, 9: instruction width.
- REG_AW, 3: register address width. The scoreboard has 2**REG_AW entries.
- HALT_OP, 9'b111000000: halt encoding. Width is INSTR_W.
- LOAD_LAT, 1: bubbles an ALU consumer needs after a load. The branch consumer needs LOAD_LAT+1.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; a single-cycle pulse.
- id_valid  in  1  ID stage holds a real instruction.
- id_instr  in  INSTR_W  ID-stage instruction.
- id_rs  in  REG_AW  ID source register.
- id_rd  in  REG_AW  ID destination / second source register.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rd  in  1  instruction reads rd.
- id_mem_read  in  1  instruction is a load.
- id_branch  in  1  instruction is a conditional branch.
- id_branch_cond  in  1  branch condition true (forwarded compare).
- run  out  1  fetch/PC enable.
- pc_init  out  1  one-cycle pulse: load PC with the start address.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush  out  1  squash IF/ID on the next edge.
- branch_taken  out  1  redirect PC to the branch target.
- done  out  1  program finished; level output.
- cycle_count  out  CNT_W  cycles spent in RUN plus DRAIN.
- stall_count  out  CNT_W  stall cycles.

Behaviour:
- Reset (async): state=IDLE. All outputs are 0, counters are 0, all scoreboard entries are 0.
- FSM is encoded as the run_state_e states IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start -> RUN. pc_init=1 for exactly the first RUN cycle.
  - Counters clear on that same edge.
- RUN:
  - run=1.
  - If id_valid, id_instr==HALT_OP and !stall -> DRAIN. drain_cnt is loaded with NUM_STAGES-3, the stages remaining after ID.
- DRAIN:
  - run=0, so no new fetches.
  - stall=0, flush=0, branch_taken=0.
  - drain_cnt decrements each cycle. At drain_cnt==0 the FSM goes to DONE.
  - Total latency, halt in ID to done high: NUM_STAGES-2 cycles. This is 3 for the default.
- DONE:
  - done=1, held until the next start.
  - start -> RUN with pc_init pulse. done drops on the same edge.
- start is ignored in RUN and DRAIN.
- Reset mid-run returns to IDLE immediately and clears the scoreboard.
- Scoreboard:
  - One counter per register, width clog2(LOAD_LAT+2).
  - A load issues on (state==RUN && id_valid && id_mem_read && !stall). Its entry [id_rd] is set to LOAD_LAT+1.
  - All other nonzero entries decrement by 1 each cycle.
  - A simultaneous issue to an entry that is currently decrementing takes the set value.
- Stall (combinational, RUN only):
  - Non-branch, id_valid: stall when (uses_rs && sb[rs]>1) || (uses_rd && sb[rd]>1).
  - Branch: stall when the relevant sb entry is >0. The branch resolves in ID and needs one extra cycle.
  - id_valid=0 never stalls.
- branch_taken = RUN && id_valid && id_branch && id_branch_cond && !stall. flush = branch_taken.
  - A stalled branch neither redirects nor flushes.
  - A halt in ID has priority over a taken branch: halt encodings never assert id_branch. If both arrive, treat it as halt.
- Counters:
  - cycle_count increments in RUN and DRAIN.
  - stall_count increments when stall=1.
  - Both saturate at all-ones; there is no wrap.

Decomposition:
- Shared package (Defs) holds run_state_e and a HALT_OP default constant.
- One natural sub-module: load_scoreboard, parametrised by REG_AW and LOAD_LAT. It takes issue, issue_rd, rs and rd, and returns rs_busy_alu, rs_busy_br, rd_busy_alu and rd_busy_br.

Test Plan:
- Start/halt: reset, start pulse, HALT_OP in ID at cycle 4 -> pc_init high for one cycle, run low from cycle 5, done high at cycle 7, cycle_count=7.
- Load-use: load r2 in ID at cycle t, ALU consumer with uses_rs on r2 at t+1 -> exactly 1 stall cycle, stall_count=1.
- Branch after load: load r3, then branch on r3 with cond=1 -> 2 stall cycles, then branch_taken=flush=1 for 1 cycle.
- Non-dependent: load r1, then consumer reading r4 -> no stall.
- Mid-run reset: assert reset during DRAIN -> run=0, done=0, counters=0 asynchronously. Start then runs cleanly with no stale stall.
- Restart and params: second start from DONE -> done drops, pc_init pulses. Rerun with NUM_STAGES=7, LOAD_LAT=2 -> drain takes 5 cycles, ALU load-use takes 2 stalls.
